// File: rtl/results_pkg.sv
// results_pkg: shared definitions for the post-game results sequencer.
//   state_t              - sequencer state encoding (IDLE, LOAD, CALC, SHOW)
//   PAGE_SCORE_BASE      - page_code of score page 0 (game i shows as 4 + i)
//   PAGE_AVG / PAGE_BEST - page_code of the average and best-score pages
//   DWELL_CYCLES_DEFAULT - default cycles per page (3 s at 50 MHz)
package results_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        SHOW = 2'd3
    } state_t;

    localparam logic [3:0] PAGE_SCORE_BASE      = 4'd4;
    localparam logic [3:0] PAGE_AVG             = 4'd8;
    localparam logic [3:0] PAGE_BEST            = 4'd9;
    localparam int         DWELL_CYCLES_DEFAULT = 150_000_000;

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: page dwell counter for the results sequencer.
// Counts enabled cycles from 0 and raises o_tc for one cycle when the count
// reaches DWELL_CYCLES-1; the count then restarts from 0. i_clear restarts
// the count synchronously and has priority over counting.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   i_clear  in  synchronous clear
//   i_enable in  count enable
//   o_tc     out terminal-count pulse
module dwell_timer
    import results_pkg::*;
#(
    parameter int DWELL_CYCLES = DWELL_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int CNT_W = $clog2(DWELL_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc = i_enable && (r_cnt == CNT_W'(DWELL_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_tc) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/results_sequencer.sv
// results_sequencer: post-game results controller for the whack-a-mole core.
// Reads every score from the score memory read port, computes sum, floor
// average and (optionally) best score, then cycles the results pages.
// Optional feature macro: RESULTS_BEST_EN adds minimum tracking and a best
// page; without it best_value/best_game are held at 0.
//   clk, reset_n  - clock, asynchronous active-low reset
//   start         - begin results sequence (ignored while busy)
//   abort         - synchronous return to IDLE (highest priority)
//   next          - advance page early (SHOW only)
//   addr_rd       - score memory read address
//   data_out      - score memory read data (1-cycle latency)
//   busy          - high outside IDLE
//   page_code     - 4+i score page, 8 average, 9 best
//   bcd_value     - value for the BCD converter
//   value_valid   - high in SHOW
//   best_value    - minimum score
//   best_game     - index of the minimum score
//
// state | meaning
// IDLE  | waiting for start, outputs at reset values
// LOAD  | issuing reads 0..NUM_GAMES-1 plus one drain cycle, capturing scores
// CALC  | registering the average, selecting page 0
// SHOW  | cycling result pages until abort
module results_sequencer
    import results_pkg::*;
#(
    parameter int NUM_GAMES    = 4,
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 10,
    parameter int DWELL_CYCLES = DWELL_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              next,
    output logic [ADDR_W-1:0] addr_rd,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic [3:0]        page_code,
    output logic [DATA_W-1:0] bcd_value,
    output logic              value_valid,
    output logic [DATA_W-1:0] best_value,
    output logic [ADDR_W-1:0] best_game
);

    localparam int LC_W  = ADDR_W + 1;
    localparam int PG_W  = ADDR_W + 1;
    localparam int SUM_W = DATA_W + ADDR_W;
`ifdef RESULTS_BEST_EN
    localparam int NUM_PAGES = NUM_GAMES + 2;
`else
    localparam int NUM_PAGES = NUM_GAMES + 1;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [LC_W-1:0]   r_ld_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_cache [NUM_GAMES];
    logic [SUM_W-1:0]  r_sum;
    logic [DATA_W-1:0] r_avg;
    logic [PG_W-1:0]   r_page;
    logic [3:0]        r_page_code;
    logic [DATA_W-1:0] r_bcd;
    logic              r_valid;
    logic [DATA_W-1:0] r_best_value;
    logic [ADDR_W-1:0] r_best_game;

    logic              w_capture;
    logic [ADDR_W-1:0] w_cap_idx;
    logic              w_tc;
    logic              w_advance;
    logic [PG_W-1:0]   w_page_nxt;
    logic [PG_W-1:0]   w_pg_sel;
    logic [3:0]        w_sel_code;
    logic [DATA_W-1:0] w_sel_value;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = LOAD;
            LOAD:    if (r_ld_cnt == LC_W'(NUM_GAMES)) w_state_nxt = CALC;
            CALC:    w_state_nxt = SHOW;
            SHOW:    w_state_nxt = SHOW;
            default: w_state_nxt = IDLE;
        endcase
        if (abort) w_state_nxt = IDLE;
    end

    // Read data lags the address by one cycle, so LOAD cycle j captures score j-1.
    assign w_capture = (r_state == LOAD) && (r_ld_cnt != '0);
    assign w_cap_idx = ADDR_W'(r_ld_cnt - LC_W'(1));

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  ((r_state != SHOW) || next),
        .i_enable (r_state == SHOW),
        .o_tc     (w_tc)
    );

    // next and expiry in the same cycle still advance a single page.
    assign w_advance  = (r_state == SHOW) && (w_tc || next);
    assign w_page_nxt = (r_page == PG_W'(NUM_PAGES - 1)) ? '0 : r_page + PG_W'(1);

    always_comb begin
        w_pg_sel    = (r_state == CALC) ? '0 : w_page_nxt;
        w_sel_code  = PAGE_SCORE_BASE;
        w_sel_value = '0;
        if (w_pg_sel < PG_W'(NUM_GAMES)) begin
            w_sel_code  = PAGE_SCORE_BASE + 4'(w_pg_sel);
            w_sel_value = r_cache[ADDR_W'(w_pg_sel)];
        end else if (w_pg_sel == PG_W'(NUM_GAMES)) begin
            w_sel_code  = PAGE_AVG;
            w_sel_value = r_avg;
        end else begin
            w_sel_code  = PAGE_BEST;
            w_sel_value = r_best_value;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ld_cnt     <= '0;
            r_addr       <= '0;
            for (int i = 0; i < NUM_GAMES; i++) r_cache[i] <= '0;
            r_sum        <= '0;
            r_avg        <= '0;
            r_page       <= '0;
            r_page_code  <= PAGE_SCORE_BASE;
            r_bcd        <= '0;
            r_valid      <= 1'b0;
            r_best_value <= '0;
            r_best_game  <= '0;
        end else if (abort) begin
            // Cache, sum and average are left as-is; they are unused in IDLE.
            r_ld_cnt     <= '0;
            r_addr       <= '0;
            r_page       <= '0;
            r_page_code  <= PAGE_SCORE_BASE;
            r_bcd        <= '0;
            r_valid      <= 1'b0;
            r_best_value <= '0;
            r_best_game  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ld_cnt     <= '0;
                        r_addr       <= '0;
                        r_sum        <= '0;
                        r_best_value <= '0;
                        r_best_game  <= '0;
                    end
                end
                LOAD: begin
                    r_ld_cnt <= r_ld_cnt + LC_W'(1);
                    r_addr   <= (r_ld_cnt < LC_W'(NUM_GAMES - 1)) ? r_addr + ADDR_W'(1) : '0;
                    if (w_capture) begin
                        r_cache[w_cap_idx] <= data_out;
                        r_sum              <= r_sum + SUM_W'(data_out);
`ifdef RESULTS_BEST_EN
                        // Strict less-than keeps the lowest index on ties.
                        if ((r_ld_cnt == LC_W'(1)) || (data_out < r_best_value)) begin
                            r_best_value <= data_out;
                            r_best_game  <= w_cap_idx;
                        end
`endif
                    end
                end
                CALC: begin
                    r_avg       <= DATA_W'(r_sum >> ADDR_W);
                    r_page      <= '0;
                    r_page_code <= w_sel_code;
                    r_bcd       <= w_sel_value;
                    r_valid     <= 1'b1;
                end
                SHOW: begin
                    if (w_advance) begin
                        r_page      <= w_page_nxt;
                        r_page_code <= w_sel_code;
                        r_bcd       <= w_sel_value;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign addr_rd     = r_addr;
    assign busy        = (r_state != IDLE);
    assign page_code   = r_page_code;
    assign bcd_value   = r_bcd;
    assign value_valid = r_valid;
    assign best_value  = r_best_value;
    assign best_game   = r_best_game;

endmodule
